// File: rtl/cva6_pma_table_pkg.sv
// Shared types for the runtime-programmable PMA table.
// Attribute order is {exec, cached, non_idem}.
package pma_pkg;

    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned MaxRules     = 16;
    localparam int unsigned IdxWidth     = $clog2(MaxRules);

    typedef struct packed {
        logic exec;
        logic cached;
        logic non_idem;
    } pma_attr_t;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] len;
        pma_attr_t               attr;
        logic                    lock;
    } pma_rule_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cva6_pma_table_match.sv
// One address against every rule; lowest matching index wins.
// Region ends are computed one bit wider so a region may end at 2^AddrWidth.
module pma_match
    import pma_pkg::*;
#(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned IdxW        = 3,
    parameter pma_attr_t   DefaultAttr = 3'b001
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [AddrWidth-1:0] i_base [NrRules],
    input  logic [AddrWidth-1:0] i_len  [NrRules],
    input  pma_attr_t            i_attr [NrRules],
    output logic                 o_hit,
    output logic [IdxW-1:0]      o_idx,
    output pma_attr_t            o_attr
);

    logic [NrRules-1:0] w_match;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        logic [AddrWidth:0] w_sum;
        logic [AddrWidth:0] w_end;

        assign w_sum = {1'b0, i_base[g]} + {1'b0, i_len[g]};
        // Anything past the top of the address space clamps to 2^AddrWidth.
        assign w_end = w_sum[AddrWidth] ? {1'b1, {AddrWidth{1'b0}}} : w_sum;
        assign w_match[g] = (i_len[g] != '0)
                         && (i_addr >= i_base[g])
                         && ({1'b0, i_addr} < w_end);
    end

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_attr = DefaultAttr;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit  = 1'b1;
                o_idx  = IdxW'(i);
                o_attr = i_attr[i];
            end
        end
    end

endmodule

// File: rtl/cva6_pma_table.sv
// Writable PMA region table with lockable entries and
// independent registered lookup ports (valid/ready, latency 1).
module cva6_pma_table
    import pma_pkg::*;
#(
    parameter int unsigned NrRules       = 8,
    parameter int unsigned NrLookupPorts = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter logic [NrRules*AddrWidth-1:0] ResetBase = '0,
    parameter logic [NrRules*AddrWidth-1:0] ResetLen  = '0,
    parameter logic [NrRules*3-1:0]         ResetAttr = '0,
    parameter logic [2:0]                   DefaultAttr = 3'b001,
    localparam int unsigned IdxW = idx_width(NrRules)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cfg_we_i,
    input  logic [IdxW-1:0]                    cfg_idx_i,
    input  logic [AddrWidth-1:0]               cfg_base_i,
    input  logic [AddrWidth-1:0]               cfg_len_i,
    input  logic [2:0]                         cfg_attr_i,
    input  logic                               cfg_lock_i,
    output logic                               cfg_err_o,
    input  logic [NrLookupPorts-1:0]           lkp_valid_i,
    output logic [NrLookupPorts-1:0]           lkp_ready_o,
    input  logic [NrLookupPorts*AddrWidth-1:0] lkp_addr_i,
    output logic [NrLookupPorts-1:0]           rsp_valid_o,
    input  logic [NrLookupPorts-1:0]           rsp_ready_i,
    output logic [NrLookupPorts-1:0]           rsp_hit_o,
    output logic [NrLookupPorts*IdxW-1:0]      rsp_idx_o,
    output logic [NrLookupPorts*3-1:0]         rsp_attr_o
);

    pma_rule_t r_rules [NrRules];
    logic      r_err;

    logic [AddrWidth-1:0] w_base [NrRules];
    logic [AddrWidth-1:0] w_len  [NrRules];
    pma_attr_t            w_attr [NrRules];
    logic                 w_idx_ok;
    logic                 w_locked;

    assign w_idx_ok  = 32'(cfg_idx_i) < NrRules;
    assign w_locked  = w_idx_ok && r_rules[cfg_idx_i].lock;
    assign cfg_err_o = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRules; i++) begin
                r_rules[i].base <= MaxAddrWidth'(ResetBase[i*AddrWidth +: AddrWidth]);
                r_rules[i].len  <= MaxAddrWidth'(ResetLen[i*AddrWidth +: AddrWidth]);
                r_rules[i].attr <= pma_attr_t'(ResetAttr[i*3 +: 3]);
                r_rules[i].lock <= 1'b0;
            end
            r_err <= 1'b0;
        end else begin
            r_err <= cfg_we_i && (!w_idx_ok || w_locked);
            if (cfg_we_i && w_idx_ok && !w_locked) begin
                r_rules[cfg_idx_i].base <= MaxAddrWidth'(cfg_base_i);
                r_rules[cfg_idx_i].len  <= MaxAddrWidth'(cfg_len_i);
                r_rules[cfg_idx_i].attr <= pma_attr_t'(cfg_attr_i);
                r_rules[cfg_idx_i].lock <= cfg_lock_i;
            end
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_view
        assign w_base[g] = r_rules[g].base[AddrWidth-1:0];
        assign w_len[g]  = r_rules[g].len[AddrWidth-1:0];
        assign w_attr[g] = r_rules[g].attr;
    end

    for (genvar p = 0; p < NrLookupPorts; p++) begin : g_port
        logic            w_hit;
        logic [IdxW-1:0] w_idx;
        pma_attr_t       w_res;
        logic            r_vld;
        logic            r_hit;
        logic [IdxW-1:0] r_idx;
        pma_attr_t       r_attr;

        pma_match #(
            .NrRules    (NrRules),
            .AddrWidth  (AddrWidth),
            .IdxW       (IdxW),
            .DefaultAttr(pma_attr_t'(DefaultAttr))
        ) u_match (
            .i_addr(lkp_addr_i[p*AddrWidth +: AddrWidth]),
            .i_base(w_base),
            .i_len (w_len),
            .i_attr(w_attr),
            .o_hit (w_hit),
            .o_idx (w_idx),
            .o_attr(w_res)
        );

        assign lkp_ready_o[p] = !r_vld || rsp_ready_i[p];

        // Lookups see the table as it was before any write on the same edge.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld  <= 1'b0;
                r_hit  <= 1'b0;
                r_idx  <= '0;
                r_attr <= pma_attr_t'(DefaultAttr);
            end else if (lkp_valid_i[p] && lkp_ready_o[p]) begin
                r_vld  <= 1'b1;
                r_hit  <= w_hit;
                r_idx  <= w_idx;
                r_attr <= w_res;
            end else if (rsp_ready_i[p]) begin
                r_vld  <= 1'b0;
            end
        end

        assign rsp_valid_o[p]            = r_vld;
        assign rsp_hit_o[p]              = r_hit;
        assign rsp_idx_o[p*IdxW +: IdxW] = r_idx;
        assign rsp_attr_o[p*3 +: 3]      = r_attr;
    end

endmodule

// File: tb/tb_cva6_pma_table.sv
// Directed bench for cva6_pma_table: six rules, two lookup ports.
// Response tuples are {valid, hit, idx[2:0], attr[2:0]}.
module tb_cva6_pma_table;

    localparam int unsigned NR = 6;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 3;
    localparam logic [NR*AW-1:0] RB = (NR*AW)'(64'h8000_0000);
    localparam logic [NR*AW-1:0] RL = (NR*AW)'(64'h4000_0000);
    localparam logic [NR*3-1:0]  RA = (NR*3)'(3'b110);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IW-1:0]     cfg_idx = '0;
    logic [AW-1:0]     cfg_base = '0;
    logic [AW-1:0]     cfg_len = '0;
    logic [2:0]        cfg_attr = '0;
    logic              cfg_lock = 1'b0;
    logic              cfg_err;
    logic [NP-1:0]     lkp_valid = '0;
    logic [NP-1:0]     lkp_ready;
    logic [NP*AW-1:0]  lkp_addr = '0;
    logic [NP-1:0]     rsp_valid;
    logic [NP-1:0]     rsp_ready = '1;
    logic [NP-1:0]     rsp_hit;
    logic [NP*IW-1:0]  rsp_idx;
    logic [NP*3-1:0]   rsp_attr;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] MISS = 8'b1_0_000_001;
    localparam logic [7:0] IDLE = 8'b0_0_000_001;

    cva6_pma_table #(
        .NrRules(NR), .NrLookupPorts(NP), .AddrWidth(AW),
        .ResetBase(RB), .ResetLen(RL), .ResetAttr(RA),
        .DefaultAttr(3'b001)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
        .cfg_attr_i(cfg_attr), .cfg_lock_i(cfg_lock),
        .cfg_err_o(cfg_err),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready),
        .lkp_addr_i(lkp_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx),
        .rsp_attr_o(rsp_attr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] resp(input int p);
        return {rsp_valid[p], rsp_hit[p], rsp_idx[p*IW +: IW], rsp_attr[p*3 +: 3]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lkp(input int p, input logic [AW-1:0] a);
        lkp_valid[p] = 1'b1;
        lkp_addr[p*AW +: AW] = a;
    endtask

    task automatic cfg_wr(input int idx, input logic [AW-1:0] b,
                          input logic [AW-1:0] l, input logic [2:0] a,
                          input logic lk);
        cfg_we = 1'b1;
        cfg_idx = IW'(idx);
        cfg_base = b;
        cfg_len = l;
        cfg_attr = a;
        cfg_lock = lk;
        cyc();
        cfg_we = 1'b0;
        cfg_lock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_cmp++; if (resp(0) !== IDLE) begin n_bad++; $display("FAIL reset_p0: got %b want %b", resp(0), IDLE); end
        n_cmp++; if (resp(1) !== IDLE) begin n_bad++; $display("FAIL reset_p1: got %b want %b", resp(1), IDLE); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        n_cmp++; if (lkp_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready: got %b want 11", lkp_ready); end
    endtask

    task automatic test_reset_rule();
        lkp(0, 64'h8000_1000);
        lkp(1, 64'hBFFF_FFFF);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_000_110) begin n_bad++; $display("FAIL rr_in: got %b want 11000110", resp(0)); end
        n_cmp++; if (resp(1) !== 8'b1_1_000_110) begin n_bad++; $display("FAIL rr_last: got %b want 11000110", resp(1)); end
        lkp(0, 64'hC000_0000);
        lkp(1, 64'h7FFF_FFFF);
        cyc();
        n_cmp++; if (resp(0) !== MISS) begin n_bad++; $display("FAIL rr_end: got %b want %b", resp(0), MISS); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL rr_below: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cyc();
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rr_drain: got %b want 00", rsp_valid); end
    endtask

    task automatic test_priority();
        cfg_wr(2, 64'h1_0000, 64'h1_0000, 3'b100, 1'b0);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL pri_err2: got %b want 0", cfg_err); end
        cfg_wr(1, 64'h1_0000, 64'h1_0000, 3'b010, 1'b0);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL pri_err1: got %b want 0", cfg_err); end
        lkp(0, 64'h1_8000);
        lkp(1, 64'h2_0000);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_001_010) begin n_bad++; $display("FAIL pri_win: got %b want 11001010", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL pri_end: got %b want %b", resp(1), MISS); end
        lkp(0, 64'h1_FFFF);
        lkp(1, 64'h0_FFFF);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_001_010) begin n_bad++; $display("FAIL pri_top: got %b want 11001010", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL pri_below: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cyc();
    endtask

    task automatic test_lock();
        cfg_wr(3, 64'h4_0000, 64'h1000, 3'b100, 1'b1);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL lock_first: got %b want 0", cfg_err); end
        cfg_wr(3, 64'h5_0000, 64'h1000, 3'b010, 1'b0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL lock_rej: got %b want 1", cfg_err); end
        cyc();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL lock_pulse: got %b want 0", cfg_err); end
        lkp(0, 64'h4_0800);
        lkp(1, 64'h5_0800);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_011_100) begin n_bad++; $display("FAIL lock_keep: got %b want 11011100", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL lock_new: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cfg_wr(NR, 64'h6_0000, 64'h1000, 3'b111, 1'b0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", cfg_err); end
        lkp(0, 64'h6_0800);
        cyc();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL oor_pulse: got %b want 0", cfg_err); end
        n_cmp++; if (resp(0) !== MISS) begin n_bad++; $display("FAIL oor_tbl: got %b want %b", resp(0), MISS); end
        lkp_valid = '0;
        cyc();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 2'b10;
        lkp(0, 64'h8000_0000);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_000_110) begin n_bad++; $display("FAIL bp_first: got %b want 11000110", resp(0)); end
        lkp(0, 64'h1_0000);
        lkp(1, 64'h1_8000);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (lkp_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_rdy%0d: got %b want 0", k, lkp_ready[0]); end
            cyc();
            lkp_valid[1] = 1'b0;
            n_cmp++; if (resp(0) !== 8'b1_1_000_110) begin n_bad++; $display("FAIL bp_hold%0d: got %b want 11000110", k, resp(0)); end
        end
        n_cmp++; if (resp(1) !== IDLE && resp(1) !== 8'b0_1_001_010) begin n_bad++; $display("FAIL bp_p1_drain: got %b want valid=0", resp(1)); end
        rsp_ready = 2'b11;
        #1;
        n_cmp++; if (lkp_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", lkp_ready[0]); end
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_001_010) begin n_bad++; $display("FAIL bp_r1: got %b want 11001010", resp(0)); end
        lkp(0, 64'h4_0000);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_011_100) begin n_bad++; $display("FAIL bp_r2: got %b want 11011100", resp(0)); end
        lkp(0, 64'hC000_0000);
        cyc();
        n_cmp++; if (resp(0) !== MISS) begin n_bad++; $display("FAIL bp_r3: got %b want %b", resp(0), MISS); end
        lkp_valid = '0;
        cyc();
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", rsp_valid[0]); end
    endtask

    task automatic test_port_indep();
        rsp_ready = 2'b10;
        lkp(0, 64'h8000_0000);
        cyc();
        lkp_valid[0] = 1'b0;
        lkp(1, 64'h1_8000);
        cyc();
        lkp_valid = '0;
        n_cmp++; if (resp(1) !== 8'b1_1_001_010) begin n_bad++; $display("FAIL indep_p1: got %b want 11001010", resp(1)); end
        n_cmp++; if (resp(0) !== 8'b1_1_000_110) begin n_bad++; $display("FAIL indep_p0: got %b want 11000110", resp(0)); end
        rsp_ready = 2'b11;
        cyc();
    endtask

    task automatic test_top_of_space();
        cfg_wr(4, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b111, 1'b0);
        lkp(0, 64'hFFFF_FFFF_FFFF_FFFF);
        lkp(1, 64'hFFFF_FFFF_FFFF_EFFF);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_100_111) begin n_bad++; $display("FAIL top_hit: got %b want 11100111", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL top_below: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cfg_wr(4, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b111, 1'b0);
        lkp(0, 64'hFFFF_FFFF_FFFF_FFFF);
        lkp(1, 64'h0);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_100_111) begin n_bad++; $display("FAIL sat_hit: got %b want 11100111", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL sat_zero: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cyc();
    endtask

    task automatic test_same_cycle();
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_base = 64'h2000_0000;
        cfg_len = 64'h1000;
        cfg_attr = 3'b101;
        lkp(0, 64'h2000_0800);
        cyc();
        cfg_we = 1'b0;
        n_cmp++; if (resp(0) !== MISS) begin n_bad++; $display("FAIL same_old: got %b want %b", resp(0), MISS); end
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_000_101) begin n_bad++; $display("FAIL same_new: got %b want 11000101", resp(0)); end
        lkp_valid = '0;
        cyc();
    endtask

    task automatic test_reset_stall();
        rsp_ready = 2'b00;
        lkp(0, 64'h2000_0000);
        cyc();
        lkp_valid = '0;
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_000_101) begin n_bad++; $display("FAIL rs_held: got %b want 11000101", resp(0)); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (resp(0) !== IDLE) begin n_bad++; $display("FAIL rs_drop: got %b want %b", resp(0), IDLE); end
        rsp_ready = 2'b11;
        cfg_wr(3, 64'h7_0000, 64'h1000, 3'b010, 1'b0);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rs_unlock: got %b want 0", cfg_err); end
        lkp(0, 64'h7_0800);
        lkp(1, 64'h2000_0000);
        cyc();
        n_cmp++; if (resp(0) !== 8'b1_1_011_010) begin n_bad++; $display("FAIL rs_rewr: got %b want 11011010", resp(0)); end
        n_cmp++; if (resp(1) !== MISS) begin n_bad++; $display("FAIL rs_tbl: got %b want %b", resp(1), MISS); end
        lkp_valid = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_reset_rule();
        test_priority();
        test_lock();
        test_back_to_back();
        test_port_indep();
        test_top_of_space();
        test_same_cycle();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
